// File: rtl/instr_fetch_queue_if.sv
// Fetch front-end bundle: instruction memory port, redirect input and the
// decode-facing queue head.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [2:0]  sel_type;
    logic        illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid, instruction, pc, sel_type, illegal,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid, instruction, pc, sel_type, illegal,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC ownership, single-outstanding memory fetch,
// in-order instruction queue with opcode pre-decode into immediate format.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    r_state, w_state_d;
    logic [63:0]   r_fetch_pc, w_fetch_pc_d;
    logic [63:0]   r_addr;
    logic          r_discard, w_discard_d;
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_after;
    logic          w_push, w_pop, w_valid;
    logic [2:0]    w_dec_sel;
    logic          w_dec_ill;

    logic [31:0]   r_instr [DEPTH];
    logic [63:0]   r_pc    [DEPTH];
    logic [2:0]    r_sel   [DEPTH];
    logic          r_ill   [DEPTH];

    always_comb begin
        w_dec_sel = 3'd0;
        w_dec_ill = 1'b0;
        case (bus.imem_rdata[6:0])
            7'b0110011, 7'b0111011: w_dec_sel = 3'd0;
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011: w_dec_sel = 3'd1;
            7'b0100011:             w_dec_sel = 3'd2;
            7'b1100011:             w_dec_sel = 3'd3;
            7'b0110111, 7'b0010111: w_dec_sel = 3'd4;
            7'b1101111:             w_dec_sel = 3'd5;
            default:                w_dec_ill = 1'b1;
        endcase
    end

    // A redirect flushes the queue, so it suppresses both push and pop.
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && bus.instr_ready && !bus.redirect;
    assign w_push        = (r_state == ST_WAIT) && bus.imem_rvalid && !r_discard && !bus.redirect;
    assign w_count_after = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.redirect || (r_count < FULL)) w_state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.imem_gnt) w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (bus.redirect || (w_count_after < FULL)) w_state_d = ST_REQ;
                    else                                        w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Any fetch still in flight when a redirect lands belongs to the old path.
    always_comb begin
        w_discard_d = r_discard;
        if ((r_state == ST_WAIT) && bus.imem_rvalid) w_discard_d = 1'b0;
        else if (bus.redirect && (r_state != ST_IDLE)) w_discard_d = 1'b1;
    end

    always_comb begin
        w_fetch_pc_d = r_fetch_pc;
        if (bus.redirect) begin
            w_fetch_pc_d = bus.redirect_pc & ~64'h3;
        end else if ((r_state == ST_REQ) && bus.imem_gnt && !r_discard) begin
            w_fetch_pc_d = r_fetch_pc + 64'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_discard  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_discard  <= w_discard_d;
            // Address is captured once per request and held until grant.
            if ((w_state_d == ST_REQ) && (r_state != ST_REQ)) r_addr <= w_fetch_pc_d;
            if (bus.redirect) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                r_count <= w_count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wptr] <= bus.imem_rdata;
            r_pc[r_wptr]    <= r_addr;
            r_sel[r_wptr]   <= w_dec_sel;
            r_ill[r_wptr]   <= w_dec_ill;
        end
    end

    assign bus.imem_req    = (r_state == ST_REQ);
    assign bus.imem_addr   = r_addr;
    assign bus.instr_valid = w_valid;
    assign bus.instruction = w_valid ? r_instr[r_rptr] : 32'd0;
    assign bus.pc          = w_valid ? r_pc[r_rptr]    : 64'd0;
    assign bus.sel_type    = w_valid ? r_sel[r_rptr]   : 3'd0;
    assign bus.illegal     = w_valid ? r_ill[r_rptr]   : 1'b0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations plus
// randomized memory/consumer/redirect traffic against a transaction-level model.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  sel;
        logic        ill;
    } entry_t;

    entry_t      mq[$];
    bit          m_req, m_pending, m_drop;
    logic [63:0] m_next_pc, m_req_addr, m_resp_addr;

    logic [6:0] op_tab  [12];
    logic [2:0] fmt_tab [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] op, output logic [2:0] sel,
                                       output logic ill);
        sel = 3'd0;
        ill = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (op_tab[i] == op) begin
                sel = fmt_tab[i];
                ill = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        m_req       = 1'b0;
        m_pending   = 1'b0;
        m_drop      = 1'b0;
        m_next_pc   = 64'h0;
        m_req_addr  = 64'h0;
        m_resp_addr = 64'h0;
    endtask

    // One clock edge of the front end seen as requests, responses and queue moves.
    task automatic model_step(input bit gnt, input bit rv, input logic [31:0] rd,
                              input bit redir, input logic [63:0] rpc, input bit rdy);
        bit     idle_before, resp, granted;
        int     size_before;
        entry_t e;
        idle_before = !m_req && !m_pending;
        size_before = mq.size();
        resp        = m_pending && rv;
        granted     = m_req && gnt;
        if (redir) begin
            mq.delete();
        end else begin
            if (size_before > 0 && rdy) void'(mq.pop_front());
            if (resp && !m_drop) begin
                e.instr = rd;
                e.pc    = m_resp_addr;
                ref_decode(rd[6:0], e.sel, e.ill);
                mq.push_back(e);
            end
        end
        if (resp) begin
            m_pending = 1'b0;
            m_drop    = 1'b0;
        end
        if (granted) begin
            m_req       = 1'b0;
            m_pending   = 1'b1;
            m_resp_addr = m_req_addr;
            if (!m_drop) m_next_pc = m_next_pc + 64'd4;
        end
        if (redir) begin
            m_next_pc = rpc & ~64'h3;
            if (m_req || m_pending) m_drop = 1'b1;
        end
        if ((resp && mq.size() < DEPTH) || (idle_before && (redir || size_before < DEPTH))) begin
            m_req      = 1'b1;
            m_req_addr = m_next_pc;
        end
    endtask

    task automatic compare_all();
        check("imem_req", bus.imem_req, m_req);
        if (m_req) check("imem_addr", bus.imem_addr, m_req_addr);
        check("instr_valid", bus.instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("instruction", bus.instruction, mq[0].instr);
            check("pc", bus.pc, mq[0].pc);
            check("sel_type", bus.sel_type, mq[0].sel);
            check("illegal", bus.illegal, mq[0].ill);
        end
    endtask

    task automatic cycle(input bit gnt, input bit rv, input logic [31:0] rd, input bit redir,
                         input logic [63:0] rpc, input bit rdy);
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
        @(posedge clk);
        #1;
        model_step(gnt, rv, rd, redir, rpc, rdy);
        compare_all();
    endtask

    task automatic fetch(input logic [31:0] rd, input bit rdy);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, rdy);
        cycle(1'b0, 1'b1, rd, 1'b0, 64'd0, rdy);
    endtask

    task automatic check_reset_values();
        check("rst imem_req", bus.imem_req, 64'd0);
        check("rst imem_addr", bus.imem_addr, 64'd0);
        check("rst instr_valid", bus.instr_valid, 64'd0);
        check("rst instruction", bus.instruction, 64'd0);
        check("rst pc", bus.pc, 64'd0);
        check("rst sel_type", bus.sel_type, 64'd0);
        check("rst illegal", bus.illegal, 64'd0);
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear without a clock edge.
    task automatic reset_dut();
        rst_n           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'd0;
        bus.instr_ready = 1'b0;
        #2;
        model_reset();
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
    endtask

    logic [31:0] stream [5];
    logic [2:0]  stream_sel [5];

    initial begin
        op_tab  = '{7'b0110011, 7'b0111011, 7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                    7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        fmt_tab = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
        stream     = '{32'h00a12023, 32'hfe000ee3, 32'h000002b7, 32'h008000ef, 32'h002081b3};
        stream_sel = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

        // Power-on reset, then immediate grant and an addi response.
        #1;
        reset_dut();
        check("first req", bus.imem_req, 64'd1);
        check("first addr", bus.imem_addr, 64'h0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        check("wait no valid", bus.instr_valid, 64'd0);
        cycle(1'b0, 1'b1, 32'h00500093, 1'b0, 64'd0, 1'b0);
        check("addi valid", bus.instr_valid, 64'd1);
        check("addi pc", bus.pc, 64'h0);
        check("addi sel", bus.sel_type, 64'd1);
        check("addi illegal", bus.illegal, 64'd0);
        check("second addr", bus.imem_addr, 64'h4);

        // Streaming with the consumer always ready.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            fetch(stream[i], 1'b1);
            check("stream sel", bus.sel_type, stream_sel[i]);
            check("stream pc", bus.pc, 64'(4 * i));
        end

        // Fill the queue, stall, then release one entry.
        reset_dut();
        fetch(32'h00500093, 1'b0);
        fetch(32'h00a12023, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
            check("full no req", bus.imem_req, 64'd0);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        check("after pop head pc", bus.pc, 64'h4);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        check("resume req", bus.imem_req, 64'd1);
        check("resume addr", bus.imem_addr, 64'h8);

        // Redirect while waiting for a response.
        reset_dut();
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 64'h1002, 1'b0);
        cycle(1'b0, 1'b1, 32'h00500093, 1'b0, 64'd0, 1'b0);
        check("redir dropped", bus.instr_valid, 64'd0);
        check("redir addr", bus.imem_addr, 64'h1000);
        fetch(32'h00500093, 1'b0);
        check("redir head pc", bus.pc, 64'h1000);

        // Redirect coincident with a response and a pop.
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h00a12023, 1'b1, 64'h2000, 1'b1);
        check("coinc empty", bus.instr_valid, 64'd0);
        check("coinc req", bus.imem_req, 64'd1);
        check("coinc addr", bus.imem_addr, 64'h2000);

        // Unrecognised opcode, then reset while a fetch is in flight.
        fetch(32'h0000007f, 1'b0);
        check("illegal flag", bus.illegal, 64'd1);
        check("illegal sel", bus.sel_type, 64'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        reset_dut();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit          gnt, rv, redir, rdy;
            logic [31:0] rd;
            logic [6:0]  op;
            int          k;
            if ($urandom_range(0, 999) < 3) begin
                reset_dut();
                continue;
            end
            k  = $urandom_range(0, 12);
            op = (k == 12) ? 7'($urandom) : op_tab[k];
            rd = {25'($urandom), op};
            gnt   = ($urandom_range(0, 1) == 1);
            rv    = m_pending && ($urandom_range(0, 4) < 2);
            redir = ($urandom_range(0, 99) < 3);
            rdy   = ($urandom_range(0, 1) == 1);
            cycle(gnt, rv, rd, redir, {$urandom, $urandom}, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
